// File: rtl/state_sequencer_if.sv
// Control and status bundle between the input-conditioning logic and the state sequencer.
interface state_sequencer_if;
    logic       start;
    logic       advance;
    logic       dir;
    logic       abort;
    logic [3:0] state_bus;
    logic       busy;
    logic       step_ack;
    logic       wrap;

    modport master (
        output start, advance, dir, abort,
        input  state_bus, busy, step_ack, wrap
    );

    modport slave (
        input  start, advance, dir, abort,
        output state_bus, busy, step_ack, wrap
    );
endinterface

// File: rtl/state_sequencer.sv
// Six-state ring sequencer (A-F) with a minimum dwell per state and a one-deep step queue.
// All outputs come from registers only; abort wins over start, advance and any queued step.
module state_sequencer #(
    parameter int unsigned DWELL = 4
) (
    input  logic              clk,
    input  logic              reset,
    state_sequencer_if.slave  bus
);
    localparam logic [2:0] ST_IDLE = 3'b000;
    localparam logic [2:0] ST_ILL  = 3'b001;
    localparam logic [2:0] ST_F    = 3'b010;
    localparam logic [2:0] ST_C    = 3'b011;
    localparam logic [2:0] ST_B    = 3'b100;
    localparam logic [2:0] ST_A    = 3'b101;
    localparam logic [2:0] ST_D    = 3'b110;
    localparam logic [2:0] ST_E    = 3'b111;

    localparam logic [3:0] CNT_LOAD = 4'(DWELL - 1);

    logic [2:0] state, state_n;
    logic [3:0] cnt, cnt_n;
    logic       pending, pending_n;
    logic       step_ack, step_ack_n;
    logic       wrap, wrap_n;
    logic       busy;
    logic       step_now;
    logic [2:0] succ;

    assign busy     = (state != ST_IDLE) && (state != ST_ILL);
    assign step_now = busy && (cnt == 4'd0) && (bus.advance || pending) && !bus.abort;

    // Ring successor in the direction sampled at this edge.
    always_comb begin
        succ = ST_IDLE;
        case (state)
            ST_A:    succ = bus.dir ? ST_F : ST_B;
            ST_B:    succ = bus.dir ? ST_A : ST_C;
            ST_C:    succ = bus.dir ? ST_B : ST_D;
            ST_D:    succ = bus.dir ? ST_C : ST_E;
            ST_E:    succ = bus.dir ? ST_D : ST_F;
            ST_F:    succ = bus.dir ? ST_E : ST_A;
            default: succ = ST_IDLE;
        endcase
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        pending_n  = pending;
        step_ack_n = 1'b0;
        wrap_n     = 1'b0;
        if (bus.abort || state == ST_ILL) begin
            state_n   = ST_IDLE;
            cnt_n     = 4'd0;
            pending_n = 1'b0;
        end else if (state == ST_IDLE) begin
            if (bus.start) begin
                state_n = ST_A;
                cnt_n   = CNT_LOAD;
            end
        end else if (step_now) begin
            state_n    = succ;
            cnt_n      = CNT_LOAD;
            pending_n  = 1'b0;
            step_ack_n = 1'b1;
            wrap_n     = bus.dir ? (state == ST_A) : (state == ST_F);
        end else if (cnt != 4'd0) begin
            // Early requests collapse into a single queued step.
            cnt_n = cnt - 4'd1;
            if (bus.advance) begin
                pending_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= 4'd0;
            pending  <= 1'b0;
            step_ack <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            pending  <= pending_n;
            step_ack <= step_ack_n;
            wrap     <= wrap_n;
        end
    end

    assign bus.state_bus = {state, busy && (cnt == 4'd0)};
    assign bus.busy      = busy;
    assign bus.step_ack  = step_ack;
    assign bus.wrap      = wrap;
endmodule

// File: tb/tb_state_sequencer.sv
// Drives a DWELL=4 and a DWELL=1 sequencer with shared stimulus and checks both against a ring model.
module tb_state_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    state_sequencer_if sb4 ();
    state_sequencer_if sb1 ();

    state_sequencer #(.DWELL(4)) dut4 (.clk(clk), .reset(rst), .bus(sb4.slave));
    state_sequencer #(.DWELL(1)) dut1 (.clk(clk), .reset(rst), .bus(sb1.slave));

    // Model: ring position 0..5 = A..F, cycles spent in the current state, one queued request.
    logic [2:0] codes [6] = '{3'b101, 3'b100, 3'b011, 3'b110, 3'b111, 3'b010};
    int  dw     [2] = '{4, 1};
    bit  m_idle [2];
    int  m_pos  [2];
    int  m_age  [2];
    bit  m_q    [2];
    bit  m_ack  [2];
    bit  m_wrap [2];

    logic i_start, i_adv, i_dir, i_abort;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [3:0] exp_bus(input int i);
        if (m_idle[i]) return 4'b0000;
        return {codes[m_pos[i]], m_age[i] >= dw[i] - 1};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_idle[i] = 1'b1; m_pos[i] = 0; m_age[i] = 0;
            m_q[i] = 1'b0; m_ack[i] = 1'b0; m_wrap[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            bit ready;
            m_ack[i]  = 1'b0;
            m_wrap[i] = 1'b0;
            ready = !m_idle[i] && (m_age[i] >= dw[i] - 1);
            if (rst || i_abort) begin
                m_idle[i] = 1'b1; m_q[i] = 1'b0; m_age[i] = 0;
            end else if (m_idle[i]) begin
                if (i_start) begin
                    m_idle[i] = 1'b0; m_pos[i] = 0; m_age[i] = 0;
                end
            end else if (ready && (i_adv || m_q[i])) begin
                m_wrap[i] = i_dir ? (m_pos[i] == 0) : (m_pos[i] == 5);
                m_pos[i]  = i_dir ? (m_pos[i] + 5) % 6 : (m_pos[i] + 1) % 6;
                m_age[i]  = 0;
                m_q[i]    = 1'b0;
                m_ack[i]  = 1'b1;
            end else begin
                if (i_adv && !ready) m_q[i] = 1'b1;
                if (m_age[i] < 100) m_age[i]++;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_bus4"},  32'(sb4.state_bus), 32'(exp_bus(0)));
        chk({tag, "_busy4"}, 32'(sb4.busy),      32'(!m_idle[0]));
        chk({tag, "_ack4"},  32'(sb4.step_ack),  32'(m_ack[0]));
        chk({tag, "_wrap4"}, 32'(sb4.wrap),      32'(m_wrap[0]));
        chk({tag, "_bus1"},  32'(sb1.state_bus), 32'(exp_bus(1)));
        chk({tag, "_busy1"}, 32'(sb1.busy),      32'(!m_idle[1]));
        chk({tag, "_ack1"},  32'(sb1.step_ack),  32'(m_ack[1]));
        chk({tag, "_wrap1"}, 32'(sb1.wrap),      32'(m_wrap[1]));
    endtask

    task automatic step(input logic s, input logic a, input logic d, input logic ab, input logic r);
        @(negedge clk);
        i_start = s; i_adv = a; i_dir = d; i_abort = ab;
        sb4.start = s; sb4.advance = a; sb4.dir = d; sb4.abort = ab;
        sb1.start = s; sb1.advance = a; sb1.dir = d; sb1.abort = ab;
        rst = r;
        if (r) begin
            #1;
            model_reset();
            check_all("rst_async");
        end
        @(posedge clk);
        model_edge();
        #1;
        check_all("edge");
    endtask

    logic [2:0] seen [$];
    logic [2:0] fwd_exp [6] = '{3'b100, 3'b011, 3'b110, 3'b111, 3'b010, 3'b101};

    initial begin
        model_reset();
        i_start = 0; i_adv = 0; i_dir = 0; i_abort = 0;
        sb4.start = 0; sb4.advance = 0; sb4.dir = 0; sb4.abort = 0;
        sb1.start = 0; sb1.advance = 0; sb1.dir = 0; sb1.abort = 0;
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);

        // Forward ring on the DWELL=4 instance with advance held.
        step(1, 0, 0, 0, 0);
        chk("start_code", 32'(sb4.state_bus[3:1]), 32'h5);
        for (int k = 0; k < 24; k++) begin
            step(0, 1, 0, 0, 0);
            if (sb4.step_ack) seen.push_back(sb4.state_bus[3:1]);
        end
        chk("fwd_count", 32'(seen.size()), 32'd6);
        for (int k = 0; k < 6 && k < seen.size(); k++) chk("fwd_code", 32'(seen[k]), 32'(fwd_exp[k]));

        // Reach E, then assert reset asynchronously.
        for (int k = 0; k < 40 && sb4.state_bus[3:1] != 3'b111; k++) step(0, 1, 0, 0, 0);
        chk("reach_e", 32'(sb4.state_bus[3:1]), 32'h7);
        step(0, 0, 0, 0, 1);
        chk("rst_bus", 32'(sb4.state_bus), 32'h0);
        step(0, 1, 0, 0, 0);
        chk("idle_adv", 32'(sb4.state_bus), 32'h0);

        // Backward wrap out of A once the dwell has elapsed.
        step(1, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        chk("bwd_code", 32'(sb4.state_bus[3:1]), 32'h2);
        chk("bwd_ack",  32'(sb4.step_ack), 32'h1);
        chk("bwd_wrap", 32'(sb4.wrap), 32'h1);

        // Queued step, then abort beating advance, start and the queue.
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("queued_ack", 32'(sb4.step_ack), 32'h1);
        chk("queued_code", 32'(sb4.state_bus[3:1]), 32'h5);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 1, 0, 1, 0);
        chk("abort_busy", 32'(sb4.busy), 32'h0);
        chk("abort_ack",  32'(sb4.step_ack), 32'h0);
        step(1, 0, 0, 0, 0);
        chk("restart_code", 32'(sb4.state_bus[3:1]), 32'h5);

        // Randomized traffic checked against the model every cycle.
        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(5) == 0, $urandom_range(2) == 0, 1'($urandom),
                 $urandom_range(29) == 0, $urandom_range(199) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
